// File: rtl/disp_share_ctrl.sv
// disp_share_ctrl: shares the 8-digit hex scan display between two 32-bit
// requesters. Ownership is arbitrated round-robin with a minimum dwell and
// changes only on frame boundaries; the owner's word is snapshotted once per
// frame and scanned out one nibble per digit slot.
module disp_share_ctrl #(
  parameter int unsigned SCAN_DIV     = 262144,
  parameter int unsigned DWELL_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [3:0]  d,
  output logic [2:0]  an,
  output logic [1:0]  gnt,
  output logic        busy
);

  localparam int unsigned      DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       DWELL_MIN = 8'(DWELL_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // One-hot grant vector for a given ownership state.
  function automatic logic [1:0] gnt_of(input state_e st);
    logic [1:0] g;
    case (st)
      ST_OWN0: g = 2'b01;
      ST_OWN1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  state_e           state_q, state_d, arb_s;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d, idx_nxt_s;
  logic [3:0]       d_q, d_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [31:0]      frame_buf_q, frame_buf_d, snap_s;
  logic [7:0]       dwell_q, dwell_d;
  logic             rr_last_q, rr_last_d;
  logic             tick_s, fb_s;

  assign tick_s    = (div_q == DIV_LAST);
  assign fb_s      = tick_s && (idx_q == 3'd7);
  assign idx_nxt_s = idx_q + 3'd1;

  // Arbitration decision as it would apply at a frame boundary.
  always_comb begin
    arb_s = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req == 2'b11) begin
          arb_s = rr_last_q ? ST_OWN0 : ST_OWN1;
        end else if (req[0]) begin
          arb_s = ST_OWN0;
        end else if (req[1]) begin
          arb_s = ST_OWN1;
        end else begin
          arb_s = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!req[0]) begin
          arb_s = req[1] ? ST_OWN1 : ST_IDLE;
        end else if (req[1] && (dwell_q >= DWELL_MIN)) begin
          arb_s = ST_OWN1;
        end else begin
          arb_s = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (!req[1]) begin
          arb_s = req[0] ? ST_OWN0 : ST_IDLE;
        end else if (req[0] && (dwell_q >= DWELL_MIN)) begin
          arb_s = ST_OWN0;
        end else begin
          arb_s = ST_OWN1;
        end
      end
      default: arb_s = ST_IDLE;
    endcase
  end

  // Next-state for divider, scan position, ownership, dwell and snapshot.
  always_comb begin
    div_d       = tick_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
    idx_d       = idx_q;
    d_d         = d_q;
    state_d     = state_q;
    gnt_d       = gnt_q;
    frame_buf_d = frame_buf_q;
    dwell_d     = dwell_q;
    rr_last_d   = rr_last_q;
    case (arb_s)
      ST_OWN0: snap_s = data0;
      ST_OWN1: snap_s = data1;
      default: snap_s = 32'h0000_0000;
    endcase
    if (fb_s) begin
      idx_d       = 3'd0;
      state_d     = arb_s;
      gnt_d       = gnt_of(arb_s);
      frame_buf_d = snap_s;
      d_d         = snap_s[3:0];
      if ((arb_s != state_q) && (arb_s != ST_IDLE)) begin
        dwell_d   = 8'd1;
        rr_last_d = (arb_s == ST_OWN1);
      end else if ((arb_s == state_q) && (arb_s != ST_IDLE)) begin
        dwell_d   = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
        rr_last_d = rr_last_q;
      end else begin
        dwell_d   = dwell_q;
        rr_last_d = rr_last_q;
      end
    end else if (tick_s) begin
      idx_d = idx_nxt_s;
      d_d   = frame_buf_q[{idx_nxt_s, 2'b00} +: 4];
    end else begin
      idx_d = idx_q;
      d_d   = d_q;
    end
  end

  // State registers; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= {DIV_W{1'b0}};
      idx_q       <= 3'd0;
      d_q         <= 4'd0;
      gnt_q       <= 2'b00;
      state_q     <= ST_IDLE;
      frame_buf_q <= 32'h0000_0000;
      dwell_q     <= 8'd0;
      rr_last_q   <= 1'b1;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      d_q         <= d_d;
      gnt_q       <= gnt_d;
      state_q     <= state_d;
      frame_buf_q <= frame_buf_d;
      dwell_q     <= dwell_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign d    = d_q;
  assign an   = idx_q;
  assign gnt  = gnt_q;
  assign busy = |gnt_q;

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Self-checking bench for disp_share_ctrl with SCAN_DIV=4, DWELL_FRAMES=2
// (one frame = 32 clocks). Each test pushes the expected digit/grant sequence
// for a frame into a scoreboard queue; the frame drain pops and compares one
// entry per digit slot.
module tb_disp_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [3:0]  d;
  logic [2:0]  an;
  logic [1:0]  gnt;
  logic        busy;

  int n_vec;
  int n_bad;

  typedef struct packed {
    logic [2:0] an;
    logic [3:0] d;
    logic [1:0] gnt;
  } exp_t;

  exp_t sb_q[$];

  disp_share_ctrl #(.SCAN_DIV(4), .DWELL_FRAMES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .data0 (data0),
    .data1 (data1),
    .d     (d),
    .an    (an),
    .gnt   (gnt),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected scan of one full frame showing word w with grant g.
  task automatic push_frame(input logic [1:0] g, input logic [31:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.an  = 3'(i);
      e.d   = w[4*i +: 4];
      e.gnt = g;
      sb_q.push_back(e);
    end
  endtask

  // Scoreboard consumer: compares n slots starting at a slot start, and
  // after slot chg applies new req/data mid-frame.
  task automatic drain_frame(input int n, input int chg, input logic [1:0] nreq,
                             input logic [31:0] nd0, input logic [31:0] nd1);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty slot=%0d", s);
      end else begin
        e = sb_q.pop_front();
        if (an !== e.an || d !== e.d || gnt !== e.gnt || busy !== (|e.gnt)) begin
          n_bad++;
          $display("FAIL slot%0d got an=%0d d=%h gnt=%b busy=%b expected an=%0d d=%h gnt=%b busy=%b",
                   s, an, d, gnt, busy, e.an, e.d, e.gnt, |e.gnt);
        end
      end
      if (s == chg) begin
        req   = nreq;
        data0 = nd0;
        data1 = nd1;
      end
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  // Reset with given inputs, released on a falling edge (start of frame 0).
  task automatic reset_release(input logic [1:0] r, input logic [31:0] a,
                               input logic [31:0] b);
    rst_n = 1'b0;
    req   = r;
    data0 = a;
    data1 = b;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 2'b00;
    data0 = 32'h0000_0000;
    data1 = 32'h0000_0000;
    #2;
    n_vec++;
    if (d !== 4'd0 || an !== 3'd0 || gnt !== 2'b00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async got d=%h an=%0d gnt=%b busy=%b expected 0/0/00/0", d, an, gnt, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (d !== 4'd0 || an !== 3'd0 || gnt !== 2'b00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held got d=%h an=%0d gnt=%b busy=%b expected 0/0/00/0", d, an, gnt, busy);
    end
  endtask

  task automatic test_idle_scan;
    reset_release(2'b00, 32'h0000_0000, 32'h0000_0000);
    push_frame(2'b00, 32'h0000_0000);
    drain_frame(8, -1, 2'b00, 32'h0000_0000, 32'h0000_0000);
  endtask

  task automatic test_single_owner;
    push_frame(2'b00, 32'h0000_0000);
    drain_frame(8, 2, 2'b01, 32'h8765_4321, 32'h0000_0000);
    push_frame(2'b01, 32'h8765_4321);
    drain_frame(8, 3, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000);
    push_frame(2'b01, 32'hFFFF_FFFF);
    drain_frame(8, -1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000);
  endtask

  task automatic test_simultaneous;
    reset_release(2'b11, 32'h0000_0000, 32'h1111_1111);
    push_frame(2'b00, 32'h0000_0000);
    push_frame(2'b01, 32'h0000_0000);
    push_frame(2'b01, 32'h0000_0000);
    push_frame(2'b10, 32'h1111_1111);
    push_frame(2'b10, 32'h1111_1111);
    push_frame(2'b01, 32'h0000_0000);
    for (int f = 0; f < 6; f++) begin
      drain_frame(8, -1, 2'b11, 32'h0000_0000, 32'h1111_1111);
    end
  endtask

  task automatic test_dwell;
    reset_release(2'b01, 32'hA5A5_5A5A, 32'hCAFE_BABE);
    push_frame(2'b00, 32'h0000_0000);
    drain_frame(8, -1, 2'b01, 32'hA5A5_5A5A, 32'hCAFE_BABE);
    push_frame(2'b01, 32'hA5A5_5A5A);
    drain_frame(8, 1, 2'b11, 32'hA5A5_5A5A, 32'hCAFE_BABE);
    push_frame(2'b01, 32'hA5A5_5A5A);
    drain_frame(8, -1, 2'b11, 32'hA5A5_5A5A, 32'hCAFE_BABE);
    push_frame(2'b10, 32'hCAFE_BABE);
    drain_frame(8, -1, 2'b11, 32'hA5A5_5A5A, 32'hCAFE_BABE);
  endtask

  task automatic test_early_release;
    reset_release(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    push_frame(2'b00, 32'h0000_0000);
    drain_frame(8, -1, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    push_frame(2'b01, 32'h1234_5678);
    drain_frame(8, 5, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    push_frame(2'b00, 32'h0000_0000);
    drain_frame(8, 1, 2'b10, 32'h1234_5678, 32'h9ABC_DEF0);
    push_frame(2'b10, 32'h9ABC_DEF0);
    drain_frame(8, 7, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
  endtask

  task automatic test_async_reset;
    // Owner 1 keeps the display (dwell not yet met); reset lands in slot 5.
    push_frame(2'b10, 32'h9ABC_DEF0);
    drain_frame(5, -1, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (d !== 4'd0 || an !== 3'd0 || gnt !== 2'b00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_midframe got d=%h an=%0d gnt=%b busy=%b expected 0/0/00/0", d, an, gnt, busy);
    end
    reset_release(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    push_frame(2'b00, 32'h0000_0000);
    push_frame(2'b01, 32'h1234_5678);
    drain_frame(8, -1, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    drain_frame(8, -1, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_idle_scan();
    test_single_owner();
    test_simultaneous();
    test_dwell();
    test_early_release();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
